// File: rtl/debug_cmd_handler_if.sv
// Link and memory signals of debug_cmd_handler.
// The master modport is the command handler and the slave modport is the link/memory side.
interface debug_cmd_handler_if #(
  parameter int unsigned AddrWidth = 25
);
  logic [7:0]           cmd;
  logic                 cmdReady;
  logic                 cmdTrigger;
  logic [7:0]           msg;
  logic [7:0]           msgLen;
  logic                 msgTrigger;
  logic [3:0]           led;
  logic                 mem_trigger;
  logic [AddrWidth-1:0] mem_addr;
  logic                 mem_ready;
  logic [15:0]          mem_rdata;
  logic                 mem_rvalid;

  modport master (
    input  cmd, cmdReady, msgTrigger, mem_ready, mem_rdata, mem_rvalid,
    output cmdTrigger, msg, msgLen, led, mem_trigger, mem_addr
  );

  modport slave (
    output cmd, cmdReady, msgTrigger, mem_ready, mem_rdata, mem_rvalid,
    input  cmdTrigger, msg, msgLen, led, mem_trigger, mem_addr
  );
endinterface

// File: rtl/debug_cmd_handler.sv
// Debug link command interpreter: LED control and buffered memory reads with byte-serial replies.
// Defining DEBUG_CMD_HANDLER_CHECKSUM_EN appends an XOR checksum byte to every reply.
module debug_cmd_handler #(
  parameter int unsigned AddrWidth = 25,
  parameter int unsigned BufWords  = 32
) (
  input logic               clk,
  input logic               rst,
  debug_cmd_handler_if.master bus
);

  localparam int unsigned IdxW      = (BufWords > 1) ? $clog2(BufWords) : 1;
  localparam logic [7:0]  BufWordsB = 8'(BufWords);
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
  localparam logic [7:0]  CsumLen   = 8'd1;
`else
  localparam logic [7:0]  CsumLen   = 8'd0;
`endif

  typedef enum logic [1:0] {StIdle, StArg, StFill, StReply} state_e;

  state_e               state;
  logic [2:0]           argCnt;
  logic [AddrWidth-1:0] argAddr;
  logic [7:0]           count;
  logic [7:0]           reqCnt;
  logic [7:0]           rspCnt;
  logic [7:0]           byteIdx;
  logic [7:0]           errByte;
  logic                 isMem;
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
  logic [7:0]           csum;
`endif
  logic [15:0]          bufMem [2**IdxW];
  logic [15:0]          word;
  logic [7:0]           nextByte;
  logic                 pop;
  logic                 accept;
  logic                 take;

  assign bus.cmdTrigger = !rst && ((state == StIdle) || (state == StArg));
  assign pop            = bus.cmdTrigger && bus.cmdReady;
  assign accept         = bus.mem_trigger && bus.mem_ready;
  assign take           = (state == StFill) && bus.mem_rvalid && (rspCnt < count);

  always_ff @(posedge clk) begin
    if (take) begin
      bufMem[rspCnt[IdxW-1:0]] <= bus.mem_rdata;
    end
  end

  // byteIdx points at the payload byte to present on the next msgTrigger.
  always_comb begin
    word     = bufMem[byteIdx[IdxW:1]];
    nextByte = errByte;
    if (isMem) begin
      nextByte = byteIdx[0] ? word[7:0] : word[15:8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= StIdle;
      argCnt          <= '0;
      argAddr         <= '0;
      count           <= '0;
      reqCnt          <= '0;
      rspCnt          <= '0;
      byteIdx         <= '0;
      errByte         <= '0;
      isMem           <= 1'b0;
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
      csum            <= '0;
`endif
      bus.msg         <= '0;
      bus.msgLen      <= '0;
      bus.led         <= '0;
      bus.mem_trigger <= 1'b0;
      bus.mem_addr    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pop) begin
            byteIdx <= '0;
            case (bus.cmd)
              8'h00: ;
              8'h80, 8'h81: begin
                bus.led[0] <= bus.cmd[0];
                bus.msg    <= bus.cmd;
                bus.msgLen <= 8'd1 + CsumLen;
                isMem      <= 1'b0;
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
                csum       <= 8'h00;
`endif
                state      <= StReply;
              end
              8'h82: begin
                argCnt <= '0;
                state  <= StArg;
              end
              default: begin
                bus.msg    <= 8'hFF;
                bus.msgLen <= 8'd2 + CsumLen;
                errByte    <= bus.cmd;
                isMem      <= 1'b0;
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
                csum       <= bus.cmd;
`endif
                state      <= StReply;
              end
            endcase
          end
        end
        StArg: begin
          if (pop) begin
            if (argCnt < 3'd4) begin
              argAddr <= {argAddr[AddrWidth-9:0], bus.cmd};
              argCnt  <= argCnt + 3'd1;
            end else if ((bus.cmd != 8'd0) && (bus.cmd <= BufWordsB)) begin
              count           <= bus.cmd;
              reqCnt          <= '0;
              rspCnt          <= '0;
              bus.mem_addr    <= argAddr;
              bus.mem_trigger <= 1'b1;
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
              csum            <= 8'h00;
`endif
              state           <= StFill;
            end else begin
              bus.msg    <= 8'hFF;
              bus.msgLen <= 8'd2 + CsumLen;
              errByte    <= 8'h82;
              isMem      <= 1'b0;
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
              csum       <= 8'h82;
`endif
              state      <= StReply;
            end
          end
        end
        StFill: begin
          if (accept) begin
            bus.mem_addr <= bus.mem_addr + 1'b1;
            reqCnt       <= reqCnt + 8'd1;
            if (reqCnt + 8'd1 == count) begin
              bus.mem_trigger <= 1'b0;
            end
          end
          if (take) begin
            rspCnt <= rspCnt + 8'd1;
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
            csum   <= csum ^ bus.mem_rdata[15:8] ^ bus.mem_rdata[7:0];
`endif
            if (rspCnt + 8'd1 == count) begin
              bus.msg    <= 8'h82;
              bus.msgLen <= {count[6:0], 1'b0} + 8'd1 + CsumLen;
              isMem      <= 1'b1;
              state      <= StReply;
            end
          end
        end
        StReply: begin
          if (bus.msgTrigger && (bus.msgLen != 8'd0)) begin
            bus.msgLen <= bus.msgLen - 8'd1;
            byteIdx    <= byteIdx + 8'd1;
            if (bus.msgLen == 8'd1) begin
              bus.msg <= 8'h00;
              state   <= StIdle;
            end else begin
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
              bus.msg <= (bus.msgLen == 8'd2) ? csum : nextByte;
`else
              bus.msg <= nextByte;
`endif
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_cmd_handler.sv
// Directed bench for debug_cmd_handler: LED commands, buffered reads, error replies and reset recovery.
module tb_debug_cmd_handler;

  localparam int unsigned AddrWidth = 25;
  localparam int unsigned BufWords  = 32;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   popCnt = 0;
  int   cyc = 0;

  logic [AddrWidth-1:0] reqLog [$];
  logic [AddrWidth-1:0] addrQ [$];
  int                   dueQ [$];
  logic [7:0]           expB [0:299];
  int                   expLen;

  debug_cmd_handler_if #(.AddrWidth(AddrWidth)) bus ();

  debug_cmd_handler #(
    .AddrWidth(AddrWidth),
    .BufWords (BufWords)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memData(input logic [AddrWidth-1:0] a);
    case (a)
      25'h10:  memData = 16'h1234;
      25'h11:  memData = 16'hABCD;
      default: memData = {a[7:0] ^ 8'hA5, a[7:0] + 8'd3};
    endcase
  endfunction

  // Memory model: in-order responses a few cycles after acceptance, mem_ready toggling.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_trigger && bus.mem_ready) begin
      reqLog.push_back(bus.mem_addr);
      addrQ.push_back(bus.mem_addr);
      dueQ.push_back(cyc + 3);
    end
    #1;
    bus.mem_rvalid = 1'b0;
    if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = memData(addrQ.pop_front());
      void'(dueQ.pop_front());
    end
    bus.mem_ready = (cyc % 2) == 0;
  end

  always @(posedge clk) begin
    if (!rst && bus.cmdTrigger && bus.cmdReady) popCnt = popCnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    bus.cmd      = b;
    bus.cmdReady = 1'b1;
    while (!bus.cmdTrigger && n < 50) begin
      tick(1);
      n++;
    end
    chk("send_wait", 32'(n < 50), 32'd1);
    tick(1);
    bus.cmdReady = 1'b0;
  endtask

  task automatic readMem(input logic [31:0] a, input logic [7:0] c);
    sendByte(8'h82);
    sendByte(a[31:24]);
    sendByte(a[23:16]);
    sendByte(a[15:8]);
    sendByte(a[7:0]);
    sendByte(c);
  endtask

  task automatic startExp(input logic [7:0] b);
    expB[0] = b;
    expLen  = 1;
  endtask

  task automatic addExp(input logic [7:0] b);
    expB[expLen] = b;
    expLen++;
  endtask

  task automatic finishExp();
`ifdef DEBUG_CMD_HANDLER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < expLen; i++) x = x ^ expB[i];
    addExp(x);
`endif
  endtask

  task automatic readReply(input string tag, input int gap);
    int n;
    n = 0;
    while (bus.msgLen == 8'd0 && n < 300) begin
      tick(1);
      n++;
    end
    chk({tag, "_start"}, 32'(n < 300), 32'd1);
    for (int i = 0; i < expLen; i++) begin
      chk({tag, "_msg"}, 32'(bus.msg), 32'(expB[i]));
      chk({tag, "_len"}, 32'(bus.msgLen), 32'(expLen - i));
      bus.msgTrigger = 1'b1;
      tick(1);
      bus.msgTrigger = 1'b0;
      if (gap > 1) tick(gap - 1);
    end
    chk({tag, "_end"}, 32'(bus.msgLen), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.cmd        = 8'h00;
    bus.cmdReady   = 1'b0;
    bus.msgTrigger = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 16'h0000;
    bus.mem_rvalid = 1'b0;
    tick(3);
    chk("rst_cmdTrigger", 32'(bus.cmdTrigger), 32'd0);
    chk("rst_msgLen", 32'(bus.msgLen), 32'd0);
    chk("rst_led", 32'(bus.led), 32'd0);
    chk("rst_memTrigger", 32'(bus.mem_trigger), 32'd0);
    rst = 1'b0;
    tick(2);
    chk("idle_cmdTrigger", 32'(bus.cmdTrigger), 32'd1);

    // Nop, Nop, LEDOn
    sendByte(8'h00);
    sendByte(8'h00);
    chk("nop_noreply", 32'(bus.msgLen), 32'd0);
    sendByte(8'h81);
    chk("ledon_led", 32'(bus.led), 32'd1);
    chk("ledon_noPop", 32'(bus.cmdTrigger), 32'd0);
    startExp(8'h81);
    finishExp();
    readReply("ledon", 2);
    chk("ledon_pops", 32'(popCnt), 32'd3);

    // ReadMem 0x10 x2
    reqLog.delete();
    readMem(32'h0000_0010, 8'd2);
    chk("rd_memTrigger", 32'(bus.mem_trigger), 32'd1);
    chk("rd_cmdTrigger", 32'(bus.cmdTrigger), 32'd0);
    startExp(8'h82);
    addExp(8'h12); addExp(8'h34); addExp(8'hAB); addExp(8'hCD);
    finishExp();
    readReply("rd", 2);
    chk("rd_nreq", 32'(reqLog.size()), 32'd2);
    if (reqLog.size() == 2) begin
      chk("rd_addr0", 32'(reqLog[0]), 32'h10);
      chk("rd_addr1", 32'(reqLog[1]), 32'h11);
    end

    // Address wrap
    reqLog.delete();
    readMem(32'h01FF_FFFF, 8'd2);
    startExp(8'h82);
    addExp(memData(25'h1FFFFFF) >> 8); addExp(8'(memData(25'h1FFFFFF)));
    addExp(memData(25'h0) >> 8);       addExp(8'(memData(25'h0)));
    finishExp();
    readReply("wrap", 1);
    chk("wrap_nreq", 32'(reqLog.size()), 32'd2);
    if (reqLog.size() == 2) begin
      chk("wrap_addr0", 32'(reqLog[0]), 32'h1FFFFFF);
      chk("wrap_addr1", 32'(reqLog[1]), 32'h0);
    end

    // Bad counts and unknown byte
    reqLog.delete();
    readMem(32'h0000_0010, 8'd0);
    chk("c0_memTrigger", 32'(bus.mem_trigger), 32'd0);
    startExp(8'hFF); addExp(8'h82); finishExp();
    readReply("c0", 2);
    readMem(32'h0000_0010, 8'(BufWords + 1));
    chk("c33_memTrigger", 32'(bus.mem_trigger), 32'd0);
    startExp(8'hFF); addExp(8'h82); finishExp();
    readReply("c33", 2);
    chk("bad_nreq", 32'(reqLog.size()), 32'd0);
    sendByte(8'h55);
    startExp(8'hFF); addExp(8'h55); finishExp();
    readReply("unk", 2);

    // Full buffer, one msgTrigger every 3 cycles
    readMem(32'h0000_0100, 8'(BufWords));
    startExp(8'h82);
    for (int i = 0; i < int'(BufWords); i++) begin
      addExp(memData(25'(32'h100 + i)) >> 8);
      addExp(8'(memData(25'(32'h100 + i))));
    end
    finishExp();
    readReply("full", 3);
    bus.msgTrigger = 1'b1;
    tick(1);
    bus.msgTrigger = 1'b0;
    tick(1);
    chk("extra_len", 32'(bus.msgLen), 32'd0);
    chk("extra_idle", 32'(bus.cmdTrigger), 32'd1);

    // Reset during fill
    reqLog.delete();
    readMem(32'h0000_0040, 8'd4);
    begin
      int n;
      n = 0;
      while (reqLog.size() == 0 && n < 20) begin
        tick(1);
        n++;
      end
      chk("mid_accept", 32'(n < 20), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_led", 32'(bus.led), 32'd0);
    chk("mid_memTrigger", 32'(bus.mem_trigger), 32'd0);
    chk("mid_memAddr", 32'(bus.mem_addr), 32'd0);
    chk("mid_cmdTrigger", 32'(bus.cmdTrigger), 32'd0);
    chk("mid_msg", 32'(bus.msg), 32'd0);
    chk("mid_msgLen", 32'(bus.msgLen), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(8);
    chk("late_msgLen", 32'(bus.msgLen), 32'd0);
    chk("late_memTrigger", 32'(bus.mem_trigger), 32'd0);
    sendByte(8'h80);
    chk("ledoff_led", 32'(bus.led), 32'd0);
    startExp(8'h80); finishExp();
    readReply("ledoff", 2);
    readMem(32'h0000_0020, 8'd1);
    startExp(8'h82);
    addExp(memData(25'h20) >> 8); addExp(8'(memData(25'h20)));
    finishExp();
    readReply("post", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
